// File: rtl/alu_pipe_if.sv
// Operand/result bus for alu_pipe: issue handshake, result handshake and flags.
// No storage of its own; the module using the slave modport owns all timing.
// Flow control is valid/ready on both the issue side and the result side.
interface alu_pipe_if #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [SHW-1:0]   in_shamt;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             flag_z;
    logic             flag_n;
    logic             flag_v;

    // Producer of operations and consumer of results.
    modport master (
        output in_valid, in_op, in_a, in_b, in_shamt, out_ready,
        input  in_ready, out_valid, out_result, flag_z, flag_n, flag_v
    );

    // The ALU itself.
    modport slave (
        input  in_valid, in_op, in_a, in_b, in_shamt, out_ready,
        output in_ready, out_valid, out_result, flag_z, flag_n, flag_v
    );
endinterface

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU: 8 ops, saturating ADD/SUB, Z/N/V flag register.
// Latency 2 edges from issue to out_valid; 1 op/cycle when out_ready stays high.
// Backpressure: held result stays stable; in_ready drops when both stages are full.
module alu_pipe #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     flush,
    alu_pipe_if.slave bus
);
    localparam int NB = WIDTH / 8;
    localparam int NL = WIDTH / 4;
    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    // Flag update mask bit positions.
    localparam int MZ = 2;
    localparam int MN = 1;
    localparam int MV = 0;

    logic             s1_valid;
    logic [3:0]       s1_op;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [SHW-1:0]   s1_shamt;

    logic             s2_valid;
    logic [WIDTH-1:0] s2_result;
    logic             s2_z;
    logic             s2_n;
    logic             s2_v;
    logic [2:0]       s2_mask;

    logic             fz;
    logic             fn;
    logic             fv;

    logic             s1_advance;
    logic             out_xfer;
    logic             accept;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             add_ovf;
    logic             sub_ovf;
    logic [WIDTH-1:0] red;
    logic [WIDTH-1:0] padd;
    logic [4:0]       lane_sum;
    logic [WIDTH-1:0] ror_res;
    logic [WIDTH-1:0] res;
    logic             ovf;
    logic [2:0]       mask;

    assign out_xfer       = s2_valid && bus.out_ready;
    assign s1_advance     = s1_valid && (!s2_valid || bus.out_ready);
    assign bus.in_ready   = !s1_valid || s1_advance;
    // Issue during a flush cycle is dropped; the producer must re-offer it.
    assign accept         = bus.in_valid && bus.in_ready && !flush;

    assign bus.out_valid  = s2_valid;
    assign bus.out_result = s2_result;
    assign bus.flag_z     = fz;
    assign bus.flag_n     = fn;
    assign bus.flag_v     = fv;

    // Execute: compute every op on the S1 operands, then pick result, overflow and flag mask.
    always_comb begin
        sum     = s1_a + s1_b;
        diff    = s1_a - s1_b;
        // Signed overflow is judged on the raw sum/difference, before clamping.
        add_ovf = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) && (sum[WIDTH-1]  != s1_a[WIDTH-1]);
        sub_ovf = (s1_a[WIDTH-1] != s1_b[WIDTH-1]) && (diff[WIDTH-1] != s1_a[WIDTH-1]);

        red = '0;
        for (int i = 0; i < NB; i++) begin
            red = red + {{(WIDTH-8){s1_a[8*i+7]}}, s1_a[8*i +: 8]}
                      + {{(WIDTH-8){s1_b[8*i+7]}}, s1_b[8*i +: 8]};
        end

        padd     = '0;
        lane_sum = '0;
        for (int j = 0; j < NL; j++) begin
            lane_sum = {s1_a[4*j+3], s1_a[4*j +: 4]} + {s1_b[4*j+3], s1_b[4*j +: 4]};
            if (lane_sum[4] != lane_sum[3]) begin
                padd[4*j +: 4] = lane_sum[4] ? 4'h8 : 4'h7;
            end else begin
                padd[4*j +: 4] = lane_sum[3:0];
            end
        end

        ror_res = '0;
        for (int k = 0; k < WIDTH; k++) begin
            ror_res[k] = s1_a[(k + int'(s1_shamt)) % WIDTH];
        end

        res  = '0;
        ovf  = 1'b0;
        mask = 3'b000;
        case (s1_op)
            4'd0: begin
                res  = add_ovf ? (s1_a[WIDTH-1] ? SMIN : SMAX) : sum;
                ovf  = add_ovf;
                mask = 3'b111;
            end
            4'd1: begin
                res  = sub_ovf ? (s1_a[WIDTH-1] ? SMIN : SMAX) : diff;
                ovf  = sub_ovf;
                mask = 3'b111;
            end
            4'd2: begin
                res  = s1_a ^ s1_b;
                mask = 3'b100;
            end
            4'd3: res = red;
            4'd4: begin
                res  = s1_a << s1_shamt;
                mask = 3'b100;
            end
            4'd5: begin
                res  = $signed(s1_a) >>> s1_shamt;
                mask = 3'b100;
            end
            4'd6: begin
                res  = ror_res;
                mask = 3'b100;
            end
            4'd7: res = padd;
            default: begin
                res  = '0;
                mask = 3'b000;
            end
        endcase
    end

    // Stage 1: capture an accepted op; empties when it moves on to S2 with no replacement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_op    <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_shamt <= '0;
        end else if (flush) begin
            s1_valid <= 1'b0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_op    <= bus.in_op;
            s1_a     <= bus.in_a;
            s1_b     <= bus.in_b;
            s1_shamt <= bus.in_shamt;
        end else if (s1_advance) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 2: hold the result and flag candidates until the consumer takes them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid  <= 1'b0;
            s2_result <= '0;
            s2_z      <= 1'b0;
            s2_n      <= 1'b0;
            s2_v      <= 1'b0;
            s2_mask   <= '0;
        end else if (flush) begin
            s2_valid <= 1'b0;
        end else if (s1_advance) begin
            s2_valid  <= 1'b1;
            s2_result <= res;
            s2_z      <= (res == '0);
            s2_n      <= res[WIDTH-1];
            s2_v      <= ovf;
            s2_mask   <= mask;
        end else if (out_xfer) begin
            s2_valid <= 1'b0;
        end
    end

    // Architectural flags: commit only on a result transfer, even in a flush cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fz <= 1'b0;
            fn <= 1'b0;
            fv <= 1'b0;
        end else if (out_xfer) begin
            if (s2_mask[MZ]) fz <= s2_z;
            if (s2_mask[MN]) fn <= s2_n;
            if (s2_mask[MV]) fv <= s2_v;
        end
    end
endmodule
